// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared opcodes, FSM state type and op-classification helpers for muldiv_iter
package muldiv_pkg;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction
  function automatic logic signed_a(input logic [2:0] op);
    return op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
  endfunction
  function automatic logic signed_b(input logic [2:0] op);
    return op == OP_MULH || op == OP_DIV || op == OP_REM;
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of shift-add multiply or restoring divide on magnitudes
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);
  logic [XLEN:0] sum, sh, diff;
  logic          ge;
  // multiply: {hi,lo} is the product/multiplier; divide: hi is remainder, lo is dividend/quotient
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    sh   = {hi, lo[XLEN-1]};
    diff = sh - {1'b0, b};
    ge   = sh >= {1'b0, b};
    hi_n = div ? (ge ? diff[XLEN-1:0] : sh[XLEN-1:0]) : sum[XLEN:1];
    lo_n = div ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV M-extension multiply/divide unit, one bit per cycle
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_DIV = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d, dz_q, dz_d, ov_q, ov_d;
  logic              out_valid_q, out_valid_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d, result_q, result_d;
  logic [XLEN-1:0]   step_hi, step_lo, a_mag, b_mag, quot_s, rem_s, res_sel;
  logic [2*XLEN-1:0] prod_s;
  logic              accept, sa, sb, dz, ov, fast;
  muldiv_step #(.XLEN(XLEN)) u_step (
    .div  (is_div(op_q)),
    .hi   (hi_q),
    .lo   (lo_q),
    .b    (b_q),
    .hi_n (step_hi),
    .lo_n (step_lo)
  );
  // decode the incoming request: operand signs, magnitudes, special divide cases
  always_comb begin
    accept = in_valid & in_ready & ~flush;
    sa     = signed_a(op) & op_a[XLEN-1];
    sb     = signed_b(op) & op_b[XLEN-1];
    a_mag  = sa ? -op_a : op_a;
    b_mag  = sb ? -op_b : op_b;
    dz     = is_div(op) && op_b == '0;
    ov     = (op == OP_DIV || op == OP_REM) && op_a == MIN && &op_b;
    fast   = FAST_DIV && (dz || ov);
  end
  // sign fix and result select from the finished magnitudes and latched flags
  always_comb begin
    prod_s  = (neg_a_q ^ neg_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot_s  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    rem_s   = neg_a_q ? -hi_q : hi_q;
    res_sel = op_q == OP_MUL ? prod_s[XLEN-1:0] :
              !op_q[2]       ? prod_s[2*XLEN-1:XLEN] :
              !op_q[1]       ? (dz_q ? '1 : ov_q ? MIN : quot_s) :
                               (ov_q ? '0 : rem_s);
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  // next state: flush wins over everything, special divides skip CALC when FAST_DIV
  always_comb begin
    state_d = state_q;
    if (flush) state_d = IDLE;
    else
      unique case (state_q)
        IDLE:    if (accept) state_d = fast ? DONE : CALC;
        CALC:    if (cnt_q == CW'(1)) state_d = DONE;
        default: if (out_valid_q && out_ready) state_d = IDLE;
      endcase
  end
  // FSM-decoded outputs
  always_comb begin
    in_ready  = state_q == IDLE;
    busy      = state_q != IDLE;
    out_valid = out_valid_q;
    result    = result_q;
  end
  // datapath next values; a fast divide-by-zero preloads the remainder with |a| so sign fix restores op_a
  always_comb begin
    op_d        = op_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    dz_d        = dz_q;
    ov_d        = ov_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    b_d         = b_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      op_d    = op;
      neg_a_d = sa;
      neg_b_d = sb;
      dz_d    = dz;
      ov_d    = ov;
      cnt_d   = CW'(XLEN);
      hi_d    = (dz && FAST_DIV) ? a_mag : '0;
      lo_d    = a_mag;
      b_d     = b_mag;
    end else if (state_q == CALC) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q - 1'b1;
    end
    if (state_q == DONE && !out_valid_q) begin
      result_d    = res_sel;
      out_valid_d = 1'b1;
    end
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (flush) begin
      out_valid_d = 1'b0;
      result_d    = result_q;
    end
  end
  // datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= '0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      op_q        <= op_d;
      neg_a_q     <= neg_a_d;
      neg_b_q     <= neg_b_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      b_q         <= b_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed checks of muldiv_iter with FAST_DIV=1 and FAST_DIV=0 side by side
module tb_muldiv_iter;
  import muldiv_pkg::*;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        f_in_ready, f_out_valid, f_busy, s_in_ready, s_out_valid, s_busy;
  logic [31:0] f_result, s_result;
  int          n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  muldiv_iter #(.XLEN(32), .FAST_DIV(1'b1)) dut_f (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(f_in_ready), .op(op),
    .op_a(op_a), .op_b(op_b), .flush(flush), .out_valid(f_out_valid),
    .out_ready(out_ready), .result(f_result), .busy(f_busy)
  );
  muldiv_iter #(.XLEN(32), .FAST_DIV(1'b0)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .op(op),
    .op_a(op_a), .op_b(op_b), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .result(s_result), .busy(s_busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    check("in_ready_f", f_in_ready, 1);
    check("in_ready_s", s_in_ready, 1);
    op = o; op_a = a; op_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; op_a = 32'h1234_5678; op_b = 32'h9abc_def0;
  endtask
  task automatic wait_done(input int lf_exp, input int ls_exp);
    int lf = 0, ls = 0;
    for (int n = 1; n <= 40 && (lf == 0 || ls == 0); n++) begin
      @(negedge clk);
      if (f_out_valid && lf == 0) lf = n;
      if (s_out_valid && ls == 0) ls = n;
    end
    check("lat_f", lf, lf_exp);
    check("lat_s", ls, ls_exp);
  endtask
  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff_valid_f", f_out_valid, 0);
    check("handoff_valid_s", s_out_valid, 0);
    check("handoff_ready_f", f_in_ready, 1);
  endtask
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lf);
    start(o, a, b);
    wait_done(lf, 33);
    check({tag, "_f"}, f_result, exp);
    check({tag, "_s"}, s_result, exp);
    take();
  endtask
  initial begin
    #1;
    check("rst_in_ready", f_in_ready, 1);
    check("rst_out_valid", f_out_valid, 0);
    check("rst_busy", f_busy, 0);
    check("rst_result", f_result, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_op("mul",    OP_MUL,    32'd7,          -32'sd3,      32'hFFFF_FFEB, 33);
    run_op("mulh",   OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("div",    OP_DIV,    -32'sd7,        32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem",    OP_REM,    -32'sd7,        32'd2,         32'hFFFF_FFFF, 33);
    run_op("divu",   OP_DIVU,   32'hFFFF_FFFE,  32'd2,         32'h7FFF_FFFF, 33);
    run_op("remu",   OP_REMU,   32'd10,         32'd3,         32'd1,         33);
    run_op("div_z",  OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_z",  OP_REM,    32'd5,          32'd0,         32'd5,         1);
    run_op("remn_z", OP_REM,    -32'sd5,        32'd0,         32'hFFFF_FFFB, 1);
    run_op("divu_z", OP_DIVU,   32'd9,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("div_ov", OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ov", OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    start(OP_DIV, 32'd100, 32'd7);
    wait_done(33, 33);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op = OP_MUL; op_a = 32'd3; op_b = 32'd3;
      @(negedge clk);
      check("stall_result", f_result, 32'd14);
      check("stall_valid", f_out_valid, 1);
      check("stall_in_ready", f_in_ready, 0);
    end
    in_valid = 1'b0;
    take();
    run_op("b2b", OP_MULHU, 32'h0001_0000, 32'h0003_0000, 32'd3, 33);
    start(OP_MUL, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy_f", f_busy, 0);
    check("flush_busy_s", s_busy, 0);
    check("flush_valid", f_out_valid, 0);
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_beats_valid", f_busy, 0);
    begin
      logic seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        seen |= f_out_valid | s_out_valid;
      end
      check("flush_no_valid", seen, 0);
    end
    check("flush_result_kept", f_result, 32'd3);
    start(OP_REMU, 32'd10, 32'd3);
    wait_done(33, 33);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_valid", s_out_valid, 0);
    check("flush_done_ready", s_in_ready, 1);
    check("flush_done_result", s_result, 32'd1);
    start(OP_MUL, 32'd11, 32'd13);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready", f_in_ready, 1);
    check("arst_busy", s_busy, 0);
    check("arst_valid", s_out_valid, 0);
    check("arst_result", s_result, 0);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst", OP_DIVU, 32'd1000, 32'd7, 32'd142, 33);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
